// File: rtl/mdu_writeback.sv
// MDU writeback stage: selects the multiply/divide result in M, registers it into W,
// and counts committed multiplies.
module mdu_writeback #(
  parameter int XLEN = 64,
  parameter int CNTW = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              StallW,
  input  logic              FlushW,
  input  logic              MDUActiveM,
  input  logic [2:0]        Funct3M,
  input  logic              W64M,
  input  logic [2*XLEN-1:0] ProdM,
  input  logic [XLEN-1:0]   QuotM,
  input  logic [XLEN-1:0]   RemM,
  output logic [XLEN-1:0]   MDUResultW,
  output logic              MDUValidW,
  output logic [CNTW-1:0]   MulCountW
);

  logic [XLEN-1:0] sel_m;
  logic [XLEN-1:0] res_m;
  logic            load_m;
  logic            is_mul_m;
  logic [XLEN-1:0] result_reg;
  logic            valid_reg;
  logic [CNTW-1:0] count_reg;
  logic [CNTW-1:0] count_next;

  always_comb begin
    sel_m = ProdM[XLEN-1:0];
    case (Funct3M)
      3'b000:                sel_m = ProdM[XLEN-1:0];
      3'b001, 3'b010, 3'b011: sel_m = ProdM[2*XLEN-1:XLEN];
      3'b100, 3'b101:        sel_m = QuotM;
      default:               sel_m = RemM;
    endcase
  end

  // Word-form ops only exist on RV64; the 32-bit build passes the selection straight through.
  generate
    if (XLEN == 64) begin : g_rv64
      assign res_m = W64M ? {{32{sel_m[31]}}, sel_m[31:0]} : sel_m;
    end else begin : g_rv32
      assign res_m = sel_m;
    end
  endgenerate

  assign load_m     = MDUActiveM & ~StallW & ~FlushW;
  assign is_mul_m   = ~Funct3M[2];
  assign count_next = count_reg + CNTW'(1);

  // Flush wins over stall; the result register itself only changes on a real load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_reg <= '0;
      valid_reg  <= 1'b0;
      count_reg  <= '0;
    end else begin
      if (FlushW) begin
        valid_reg <= 1'b0;
      end else if (!StallW) begin
        valid_reg <= MDUActiveM;
      end
      if (load_m) begin
        result_reg <= res_m;
        if (is_mul_m) begin
          count_reg <= count_next;
        end
      end
    end
  end

  assign MDUResultW = result_reg;
  assign MDUValidW  = valid_reg;
  assign MulCountW  = count_reg;

endmodule
